// File: rtl/wbuf_pkg.sv
// wbuf shared types and widths.
// Entry layout for the write-back buffer storage.
package wbuf_pkg;

    localparam int ADR_W  = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              valid;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/wbuf_match.sv
// DEPTH-way address comparator.
// Returns a one-hot vector of valid entries matching adr.
module wbuf_match
    import wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  entry_t [DEPTH-1:0] ents,
    input  logic [ADR_W-1:0]   adr,
    output logic [DEPTH-1:0]   hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = ents[i].valid
                  && (ents[i].adr == adr);
        end
    end

endmodule

// File: rtl/wbuf.sv
// Coalescing write-back buffer between the
// cache eviction port and the memory write port.
module wbuf
    import wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [ADR_W-1:0]       in_adr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   lookup_en,
    input  logic [ADR_W-1:0]       lookup_adr,
    output logic                   hit_valid,
    output logic [DATA_W-1:0]      hit_data,
    output logic                   mem_wen,
    output logic [ADR_W-1:0]       mem_adr,
    output logic [DATA_W-1:0]      mem_data,
    input  logic                   mem_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t [DEPTH-1:0] ents;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      cnt;

    logic               pop;
    logic [DEPTH-1:0]   head_oh;
    logic [DEPTH-1:0]   ins_hit;
    logic [DEPTH-1:0]   co_vec;
    logic [DEPTH-1:0]   lk_hit;
    logic [DATA_W-1:0]  lk_data;
    logic               coal;
    logic               app;
    logic               drop;

    assign count    = cnt;
    assign full     = (cnt == CW'(DEPTH));
    assign mem_wen  = (cnt != '0);
    assign mem_adr  = ents[head].adr;
    assign mem_data = ents[head].data;

    assign pop     = mem_wen && mem_ready;
    assign head_oh = DEPTH'(1) << head;

    wbuf_match #(
        .DEPTH (DEPTH)
    ) u_ins_match (
        .ents (ents),
        .adr  (in_adr),
        .hit  (ins_hit)
    );

    wbuf_match #(
        .DEPTH (DEPTH)
    ) u_lk_match (
        .ents (ents),
        .adr  (lookup_adr),
        .hit  (lk_hit)
    );

    // Head leaving this cycle cannot absorb data.
    assign co_vec = ins_hit
                  & ~(pop ? head_oh : '0);

    assign coal = in_valid && (co_vec != '0);
    assign app  = in_valid && !coal
               && (!full || pop);
    assign drop = in_valid && !coal && !app;

    always_comb begin
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lk_hit[i]) begin
                lk_data = lk_data | ents[i].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ents      <= '0;
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            hit_valid <= 1'b0;
            hit_data  <= '0;
        end else begin
            if (pop) begin
                ents[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            if (coal) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (co_vec[i]) begin
                        ents[i].data <= in_data;
                    end
                end
            end
            // Placed after pop: full+pop reuses the head slot.
            if (app) begin
                ents[tail] <= '{
                    valid: 1'b1,
                    adr:   in_adr,
                    data:  in_data
                };
                tail <= tail + 1'b1;
            end
            unique case ({app, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            hit_valid <= lookup_en && (lk_hit != '0);
            hit_data  <= lookup_en ? lk_data : '0;
        end
    end

endmodule

// File: tb/tb_wbuf.sv
// Directed self-checking bench for wbuf.
// Vectors and expected values are hand-computed.
module tb_wbuf;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_adr;
    logic [15:0] in_data;
    logic        lookup_en;
    logic [15:0] lookup_adr;
    logic        hit_valid;
    logic [15:0] hit_data;
    logic        mem_wen;
    logic [15:0] mem_adr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [2:0]  count;
    logic        full;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] log_adr[$];
    logic [15:0] log_dat[$];

    always #5 clk = ~clk;

    wbuf #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_adr     (in_adr),
        .in_data    (in_data),
        .lookup_en  (lookup_en),
        .lookup_adr (lookup_adr),
        .hit_valid  (hit_valid),
        .hit_data   (hit_data),
        .mem_wen    (mem_wen),
        .mem_adr    (mem_adr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    always @(posedge clk) begin
        if (!reset && mem_wen && mem_ready) begin
            log_adr.push_back(mem_adr);
            log_dat.push_back(mem_data);
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [15:0] a,
                       input logic [15:0] d);
        in_valid = 1'b1;
        in_adr   = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        mem_ready = 1'b1;
        while (count != 0 && n < 20) begin
            step();
            n++;
        end
        mem_ready = 1'b0;
        check("drain_done", count, 0);
    endtask

    task automatic chk_log(input string tag,
                           input int idx,
                           input logic [15:0] a,
                           input logic [15:0] d);
        if (idx < log_adr.size()) begin
            check({tag, "_adr"}, log_adr[idx], a);
            check({tag, "_dat"}, log_dat[idx], d);
        end else begin
            check({tag, "_missing"}, 1, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_adr     = '0;
        in_data    = '0;
        lookup_en  = 1'b0;
        lookup_adr = '0;
        mem_ready  = 1'b0;
        #1;
        do_reset();

        check("rst_count", count, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_hitv", hit_valid, 0);
        check("rst_hitd", hit_data, 0);

        // Basic FIFO
        ins(16'h0010, 16'hAAAA);
        ins(16'h0020, 16'hBBBB);
        check("fifo_count", count, 2);
        check("fifo_wen", mem_wen, 1);
        check("fifo_adr", mem_adr, 16'h0010);
        check("fifo_dat", mem_data, 16'hAAAA);
        log_adr.delete();
        log_dat.delete();
        mem_ready = 1'b1;
        step();
        check("fifo_c1", count, 1);
        check("fifo_adr2", mem_adr, 16'h0020);
        step();
        mem_ready = 1'b0;
        check("fifo_c0", count, 0);
        check("fifo_wen0", mem_wen, 0);
        check("fifo_nwr", log_adr.size(), 2);
        chk_log("fifo_w0", 0, 16'h0010, 16'hAAAA);
        chk_log("fifo_w1", 1, 16'h0020, 16'hBBBB);

        // Coalesce and lookup hit
        ins(16'h0030, 16'h1111);
        ins(16'h0030, 16'h2222);
        check("coal_count", count, 1);
        check("coal_dat", mem_data, 16'h2222);
        lookup_en  = 1'b1;
        lookup_adr = 16'h0030;
        step();
        lookup_en = 1'b0;
        check("coal_hitv", hit_valid, 1);
        check("coal_hitd", hit_data, 16'h2222);
        step();
        check("coal_pulse", hit_valid, 0);
        drain();

        // Full and overflow
        log_adr.delete();
        log_dat.delete();
        for (int i = 0; i < 4; i++) begin
            ins(16'h0100 + 16'(i), 16'h00D0 + 16'(i));
        end
        check("full_full", full, 1);
        check("full_count", count, 4);
        check("full_ovf0", overflow, 0);
        ins(16'h0104, 16'h00D4);
        check("ovf_count", count, 4);
        check("ovf_full", full, 1);
        check("ovf_ovf", overflow, 1);
        drain();
        check("ovf_nwr", log_adr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk_log("ovf_w", i, 16'h0100 + 16'(i),
                    16'h00D0 + 16'(i));
        end
        check("ovf_sticky", overflow, 1);
        do_reset();
        check("ovf_rst", overflow, 0);

        // Full with simultaneous pop
        log_adr.delete();
        log_dat.delete();
        for (int i = 0; i < 4; i++) begin
            ins(16'h0200 + 16'(i), 16'h00E0 + 16'(i));
        end
        mem_ready = 1'b1;
        ins(16'h0204, 16'h00E4);
        mem_ready = 1'b0;
        check("fpop_count", count, 4);
        check("fpop_full", full, 1);
        check("fpop_ovf", overflow, 0);
        check("fpop_head", mem_adr, 16'h0201);
        drain();
        check("fpop_nwr", log_adr.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk_log("fpop_w", i, 16'h0200 + 16'(i),
                    16'h00E0 + 16'(i));
        end

        // Pop/coalesce race, lookup sees pre-edge
        log_adr.delete();
        log_dat.delete();
        ins(16'h0040, 16'h4444);
        mem_ready  = 1'b1;
        lookup_en  = 1'b1;
        lookup_adr = 16'h0040;
        ins(16'h0040, 16'h5555);
        check("race_count", count, 1);
        check("race_adr", mem_adr, 16'h0040);
        check("race_dat", mem_data, 16'h5555);
        check("race_hitv", hit_valid, 1);
        check("race_hitd", hit_data, 16'h4444);
        lookup_adr = 16'h0099;
        step();
        lookup_en = 1'b0;
        mem_ready = 1'b0;
        check("miss_hitv", hit_valid, 0);
        check("miss_hitd", hit_data, 0);
        check("race_c0", count, 0);
        check("race_nwr", log_adr.size(), 2);
        chk_log("race_w0", 0, 16'h0040, 16'h4444);
        chk_log("race_w1", 1, 16'h0040, 16'h5555);

        // Reset mid-drain
        for (int i = 0; i < 5; i++) begin
            ins(16'h0300 + 16'(i), 16'h00F0 + 16'(i));
        end
        check("mid_ovf", overflow, 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        check("mid_count", count, 3);
        mem_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        mem_ready = 1'b0;
        check("mid_rcount", count, 0);
        check("mid_rwen", mem_wen, 0);
        check("mid_rovf", overflow, 0);
        check("mid_rfull", full, 0);
        lookup_en  = 1'b1;
        lookup_adr = 16'h0302;
        step();
        lookup_en = 1'b0;
        check("mid_lkv", hit_valid, 0);
        check("mid_lkd", hit_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
